// File: rtl/writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_queue_pkg
// Description : Shared widths and the pending-write entry type for the
//               writeback queue and its forwarding matcher.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_queue_pkg;

    localparam int REG_NUM_W = 3;
    localparam int DATA_W    = 16;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_NUM_W-1:0] writenum;
        logic [DATA_W-1:0]    data;
    } wbq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wbq_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wbq_fwd_match
// Description : Youngest-match selector. Walks the occupied entries from the
//               oldest (head) towards the tail so the last match found is
//               the youngest one.
// Revision    : 1.0 - initial release
// ============================================================================
module wbq_fwd_match
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
)
(
    input  logic [DEPTH-1:0]       valid,
    input  wbq_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]       head,
    input  logic [REG_NUM_W-1:0]   readnum,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);

    logic [PTR_W-1:0] idx;

    // Age-ordered scan; later (younger) matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (entries[idx].writenum == readnum)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : writeback_queue
// Description : FIFO of pending register-file writes. Entries drain into the
//               register file whenever its write port is free, and readers
//               can forward the youngest pending value for a register.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_NUM_W-1:0] in_writenum,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 drain_en,
    output logic                 write,
    output logic [REG_NUM_W-1:0] writenum,
    output logic [DATA_W-1:0]    data_in,
    input  logic [REG_NUM_W-1:0] fwd_readnum,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data,
    output logic [3:0]           count
);

    localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    wbq_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]       valid;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [3:0]             occ;
    logic                   push;
    logic                   pop;
    logic                   not_empty;
    logic                   match_hit;
    logic [DATA_W-1:0]      match_data;
    wbq_entry_t             head_entry;

    // Outputs are forced quiet while rst_n is low so nothing reaches the
    // register file on the reset edge, even with stale state before it.
    assign not_empty  = rst_n && (occ != 4'd0);
    assign in_ready   = rst_n && (occ < DEPTH_CNT);
    assign push       = in_valid && in_ready;
    assign write      = not_empty && drain_en;
    assign pop        = write;
    assign head_entry = entries[head];
    assign writenum   = not_empty ? head_entry.writenum : '0;
    assign data_in    = not_empty ? head_entry.data : '0;
    assign count      = occ;
    assign fwd_hit    = rst_n && match_hit;
    assign fwd_data   = (rst_n && match_hit) ? match_data : '0;

    // Pointer, occupancy and per-entry valid bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            if (push) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 4'd1;
                2'b01:   occ <= occ - 4'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Entry payload; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= {in_writenum, in_data};
        end
    end

    wbq_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd_match (
        .valid   (valid),
        .entries (entries),
        .head    (head),
        .readnum (fwd_readnum),
        .hit     (match_hit),
        .data    (match_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_queue
// Description : Self-checking bench for writeback_queue with a scoreboard of
//               expected register-file writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_writenum;
    logic [15:0] in_data;
    logic        drain_en;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  fwd_readnum;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [3:0]  count;

    logic [18:0] sb[$];
    logic [18:0] exp_e;
    int          total = 0;
    int          bad   = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_writenum (in_writenum),
        .in_data     (in_data),
        .drain_en    (drain_en),
        .write       (write),
        .writenum    (writenum),
        .data_in     (data_in),
        .fwd_readnum (fwd_readnum),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_writenum = '0; in_data = '0;
        drain_en = 1'b1; fwd_readnum = '0;
        step(); step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", write); end
        total++; if ({writenum, data_in} !== 19'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", {writenum, data_in}); end
        total++; if ({fwd_hit, fwd_data} !== 17'd0) begin bad++; $display("FAIL reset_fwd got=%h exp=0", {fwd_hit, fwd_data}); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_writenum = 3'd3; in_data = 16'h1234; drain_en = 1'b1;
        #1;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL single_empty_write got=%b exp=0", write); end
        if (in_ready) sb.push_back({in_writenum, in_data});
        step();
        in_valid = 1'b0;
        #1;
        total++; if (write !== 1'b1) begin bad++; $display("FAIL single_write got=%b exp=1", write); end
        if (write && sb.size() > 0) begin
            exp_e = sb.pop_front();
            total++; if ({writenum, data_in} !== exp_e) begin bad++; $display("FAIL single_data got=%h exp=%h", {writenum, data_in}, exp_e); end
        end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
        step();
        total++; if (count !== 4'd0 || write !== 1'b0) begin bad++; $display("FAIL single_after got=%0d/%b exp=0/0", count, write); end
    endtask

    task automatic test_full();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_writenum = 3'(i + 1); in_data = 16'hA000 + 16'(i);
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b exp=1", i, in_ready); end
            else sb.push_back({in_writenum, in_data});
            step();
        end
        total++; if (count !== 4'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, in_ready); end
        total++; if (write !== 1'b0) begin bad++; $display("FAIL full_hold_write got=%b exp=0", write); end
        in_valid = 1'b1; in_writenum = 3'd7; in_data = 16'hBEEF;
        step(); step();
        total++; if (count !== 4'd4) begin bad++; $display("FAIL full_ignored got=%0d exp=4", count); end
        in_valid = 1'b0; drain_en = 1'b1;
        for (int c = 0; c < 8 && sb.size() > 0; c++) begin
            #1;
            if (write) begin
                exp_e = sb.pop_front();
                total++; if ({writenum, data_in} !== exp_e) begin bad++; $display("FAIL full_drain got=%h exp=%h", {writenum, data_in}, exp_e); end
            end
            step();
        end
        total++; if (sb.size() != 0 || count !== 4'd0) begin bad++; $display("FAIL full_drain_done left=%0d count=%0d exp=0/0", sb.size(), count); end
        sb.delete();
    endtask

    task automatic test_forward();
        drain_en = 1'b0; fwd_readnum = 3'd2;
        in_valid = 1'b1; in_writenum = 3'd2; in_data = 16'h0001;
        sb.push_back({in_writenum, in_data});
        step();
        in_data = 16'h0002;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0001) begin bad++; $display("FAIL fwd_first got=%b/%h exp=1/0001", fwd_hit, fwd_data); end
        sb.push_back({in_writenum, in_data});
        step();
        in_valid = 1'b0;
        #1;
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0002) begin bad++; $display("FAIL fwd_youngest got=%b/%h exp=1/0002", fwd_hit, fwd_data); end
        fwd_readnum = 3'd5;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin bad++; $display("FAIL fwd_miss got=%b/%h exp=0/0000", fwd_hit, fwd_data); end
        fwd_readnum = 3'd2; drain_en = 1'b1;
        for (int c = 0; c < 6 && sb.size() > 0; c++) begin
            #1;
            if (write) begin
                exp_e = sb.pop_front();
                total++; if ({writenum, data_in} !== exp_e) begin bad++; $display("FAIL fwd_drain got=%h exp=%h", {writenum, data_in}, exp_e); end
            end
            step();
            if (sb.size() == 1) begin
                total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h0002) begin bad++; $display("FAIL fwd_after_pop got=%b/%h exp=1/0002", fwd_hit, fwd_data); end
            end
        end
        total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000 || sb.size() != 0) begin bad++; $display("FAIL fwd_drained got=%b/%h exp=0/0000", fwd_hit, fwd_data); end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        drain_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_writenum = 3'(i); in_data = 16'hC000 + 16'(i);
            sb.push_back({in_writenum, in_data});
            step();
        end
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_writenum = 3'(i + 2); in_data = 16'h5A00 + 16'(i * 7);
            #1;
            total++; if (write !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_hs%0d got=%b/%b exp=1/1", i, write, in_ready); end
            if (write && sb.size() > 0) begin
                exp_e = sb.pop_front();
                total++; if ({writenum, data_in} !== exp_e) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, {writenum, data_in}, exp_e); end
            end
            if (in_ready) sb.push_back({in_writenum, in_data});
            step();
            total++; if (count !== 4'd2) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=2", i, count); end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6 && sb.size() > 0; c++) begin
            #1;
            if (write) begin
                exp_e = sb.pop_front();
                total++; if ({writenum, data_in} !== exp_e) begin bad++; $display("FAIL b2b_tail got=%h exp=%h", {writenum, data_in}, exp_e); end
            end
            step();
        end
        total++; if (sb.size() != 0 || count !== 4'd0) begin bad++; $display("FAIL b2b_done left=%0d count=%0d exp=0/0", sb.size(), count); end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_writenum = 3'd6; in_data = 16'h7700 + 16'(i);
            step();
        end
        in_valid = 1'b0; fwd_readnum = 3'd6;
        #1;
        total++; if (count !== 4'd3 || fwd_hit !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%0d/%b exp=3/1", count, fwd_hit); end
        drain_en = 1'b1; rst_n = 1'b0;
        #1;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL rmid_edge_write got=%b exp=0", write); end
        step();
        total++; if (count !== 4'd0 || write !== 1'b0 || fwd_hit !== 1'b0) begin bad++; $display("FAIL rmid_flush got=%0d/%b/%b exp=0/0/0", count, write, fwd_hit); end
        rst_n = 1'b1;
        step();
        total++; if (count !== 4'd0 || write !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_after got=%0d/%b/%b exp=0/0/1", count, write, in_ready); end
    endtask

    task automatic test_empty_drain();
        drain_en = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (write !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL empty_drain%0d got=%b/%0d exp=0/0", i, write, count); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        test_empty_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of pending-write entries (power of two, 2..8).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  producer offers a result this cycle.
REQ-005 The block SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-006 The block SHALL have port in_writenum  input  3  destination register number of offered result.
REQ-007 The block SHALL have port in_data  input  16  offered result value.
REQ-008 The block SHALL have port drain_en  input  1  register-file write port is free this cycle.
REQ-009 The block SHALL have port write  output  1  register-file write strobe.
REQ-010 The block SHALL have port writenum  output  3  register-file destination number.
REQ-011 The block SHALL have port data_in  output  16  register-file write data.
REQ-012 The block SHALL have port fwd_readnum  input  3  register number being read by the datapath.
REQ-013 The block SHALL have port fwd_hit  output  1  a pending entry targets fwd_readnum.
REQ-014 The block SHALL have port fwd_data  output  16  value of youngest matching pending entry.
REQ-015 The block SHALL have port count  output  4  number of occupied entries (0..DEPTH).

Function
REQ-016 Entries SHALL be held in FIFO order with head/tail pointers wrapping modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH); no pass-through when full, even if a pop occurs the same cycle.
REQ-018 Push SHALL occur on a rising edge where in_valid && in_ready; tail entry captures {in_writenum, in_data}.
REQ-019 write SHALL equal (count != 0) && drain_en, combinationally; writenum/data_in SHALL show the head entry whenever count != 0, else 0.
REQ-020 Pop SHALL occur on every rising edge where write is 1, coincident with the register-file capture.
REQ-021 Latency: an entry pushed at edge N SHALL be at the earliest written at edge N+1 (write high during cycle N..N+1 if it is head).
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push-only +1; pop-only -1.
REQ-023 Empty: write SHALL be 0 regardless of drain_en; no pointer movement on pop side.
REQ-024 drain_en low SHALL hold all entries; pushes continue until full.
REQ-025 Multiple entries with the same destination SHALL all be retained and drained in order (no merging).
REQ-026 fwd_hit/fwd_data SHALL be combinational over occupied entries only; on multiple matches the youngest (nearest tail) wins.
REQ-027 An entry popped at edge N SHALL not contribute to fwd_hit after edge N; an entry pushed at edge N SHALL contribute from edge N.
REQ-028 fwd_data SHALL be 0 when fwd_hit is 0.
REQ-029 in_valid while in_ready is 0 SHALL be ignored without state change; producer holds its offer.

Reset
REQ-030 On a rising edge with rst_n low the queue SHALL flush: count=0, pointers=0, all entries invalid.
REQ-031 During and after reset, write, writenum, data_in, fwd_hit, fwd_data SHALL be 0 and in_ready SHALL be 1 once rst_n is high.
REQ-032 Reset mid-operation SHALL discard pending entries; no register-file write is issued on the reset edge.

Structure
REQ-033 A shared package SHALL hold the REG_NUM_W=3 and DATA_W=16 constants and the entry typedef {writenum, data}.
REQ-034 Storage SHALL be a per-entry valid bit plus entry array; one sub-module, wbq_fwd_match, SHALL perform youngest-match priority selection.

Verification
REQ-035 Push {R3,0x1234}, drain_en=1 -> next cycle write=1, writenum=3, data_in=0x1234; count returns to 0 after one edge.
REQ-036 drain_en=0, push 4 entries -> count=4, in_ready=0; 5th offer ignored; drain_en=1 -> 4 writes in push order.
REQ-037 Push {R2,0x0001} then {R2,0x0002}, drain_en=0, fwd_readnum=2 -> fwd_hit=1, fwd_data=0x0002; fwd_readnum=5 -> fwd_hit=0, fwd_data=0.
REQ-038 count=2, push and pop same edge -> count stays 2; repeat 10 cycles across pointer wrap -> data order preserved.
REQ-039 3 entries pending, rst_n low one edge -> count=0, write=0, fwd_hit=0; no write on reset edge.
REQ-040 Empty queue, drain_en=1 -> write stays 0 for 5 cycles.
